// File: rtl/au_pkg.sv
// Shared encodings and helpers for the arithmetic-unit issue/capture stage.
package au_pkg;

    localparam logic [1:0] SEL_ADD = 2'b00;
    localparam logic [1:0] SEL_SUB = 2'b01;
    localparam logic [1:0] SEL_BCD = 2'b10;
    localparam logic [1:0] SEL_CLA = 2'b11;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    // A BCD add with a non-decimal digit on either operand is flagged, not blocked.
    function automatic logic bcd_err(input logic [1:0] sel, input logic [3:0] a,
                                     input logic [3:0] b);
        return (sel == SEL_BCD) && ((a > BCD_MAX) || (b > BCD_MAX));
    endfunction

endpackage

// File: rtl/au_result_fifo.sv
// Small power-of-two result FIFO with registered head; empty reads as zero.
module au_result_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned EW    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [EW-1:0]              push_data,
    input  logic                       pop,
    output logic [EW-1:0]              head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && (count_q < CntW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    assign head_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

endmodule

// File: rtl/au_issue_ctrl.sv
// Issue/capture stage: holds operands on the AU for one execute cycle, then
// queues the result with its tag and BCD-error flag for a downstream consumer.
module au_issue_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic [1:0]       au_sel,
    input  logic [WIDTH-1:0] au_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [1:0]       out_sel,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [15:0]      op_count
);

    import au_pkg::*;

    localparam int unsigned EntryW = WIDTH + 2 + TAG_W + 1;
    localparam int unsigned CntW   = $clog2(DEPTH) + 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [1:0]         sel_q;
    logic [TAG_W-1:0]   tag_q;
    logic               err_q;
    logic [15:0]        op_count_q;
    logic [CntW-1:0]    count;
    logic               accept;
    logic               push;
    logic               pop;
    logic [EntryW-1:0]  push_data;
    logic [EntryW-1:0]  head_data;

    // Ready depends only on registered state, never on in_valid or out_ready.
    assign in_ready = (state_q == ST_IDLE) && (count < CntW'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign push     = (state_q == ST_EXEC);
    assign pop      = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= SEL_ADD;
            tag_q      <= '0;
            err_q      <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= in_a;
                b_q   <= in_b;
                sel_q <= in_sel;
                tag_q <= in_tag;
                err_q <= bcd_err(in_sel, in_a[3:0], in_b[3:0]);
            end
            if (push) begin
                op_count_q <= op_count_q + 16'd1;
            end
        end
    end

    assign push_data = {au_result, sel_q, tag_q, err_q};

    au_result_fifo #(
        .DEPTH (DEPTH),
        .EW    (EntryW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    assign au_a      = a_q;
    assign au_b      = b_q;
    assign au_sel    = sel_q;
    assign out_valid = (count != '0);
    assign {out_result, out_sel, out_tag, out_err} = head_data;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_au_issue_ctrl.sv
// Randomised and directed bench for au_issue_ctrl against a queue-based model.
module tb_au_issue_ctrl;

    localparam int unsigned W = 4;
    localparam int unsigned D = 2;
    localparam int unsigned T = 2;

    typedef struct packed {
        logic [W-1:0] res;
        logic [1:0]   sel;
        logic [T-1:0] tag;
        logic         err;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [1:0]   in_sel = '0;
    logic [T-1:0] in_tag = '0;
    logic [W-1:0] au_a, au_b, au_result;
    logic [1:0]   au_sel;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic [1:0]   out_sel;
    logic [T-1:0] out_tag;
    logic         out_err;
    logic [15:0]  op_count;

    int vectors = 0;
    int miscompares = 0;

    // Model state: ops queued, one op waiting to land, last operands, result count.
    ent_t         m_q[$];
    ent_t         m_op;
    bit           m_pending = 0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [1:0]   m_sel = '0;
    logic [15:0]  m_cnt = '0;
    bit           last_acc = 0;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] au_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] s);
        int unsigned d;
        case (s)
            2'b00: return W'(a + b);
            2'b01: return W'(a - b);
            2'b10: begin
                d = int'(a[3:0]) + int'(b[3:0]);
                if (d > 9) d = d + 6;
                return W'(d % 16);
            end
            default: return W'(a + b);
        endcase
    endfunction

    // Stand-in for the parent's combinational arithmetic unit.
    assign au_result = au_ref(au_a, au_b, au_sel);

    au_issue_ctrl #(
        .WIDTH (W),
        .DEPTH (D),
        .TAG_W (T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sel     (in_sel),
        .in_tag     (in_tag),
        .au_a       (au_a),
        .au_b       (au_b),
        .au_sel     (au_sel),
        .au_result  (au_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_sel    (out_sel),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .op_count   (op_count)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        bit acc;
        acc = in_valid && !m_pending && (m_q.size() < D);
        if (rst) begin
            m_q.delete();
            m_pending = 0;
            m_a = '0; m_b = '0; m_sel = '0;
            m_cnt = '0;
            last_acc = 0;
            return;
        end
        if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (m_pending) begin
            m_q.push_back(m_op);
            m_cnt = m_cnt + 16'd1;
            m_pending = 0;
        end
        if (acc) begin
            m_a = in_a; m_b = in_b; m_sel = in_sel;
            m_op.res = au_ref(in_a, in_b, in_sel);
            m_op.sel = in_sel;
            m_op.tag = in_tag;
            m_op.err = (in_sel == 2'b10) && ((in_a[3:0] > 9) || (in_b[3:0] > 9));
            m_pending = 1;
        end
        last_acc = acc;
    endtask

    task automatic compare();
        ent_t h;
        h = (m_q.size() > 0) ? m_q[0] : '0;
        check("in_ready", 32'(in_ready), 32'(!m_pending && (m_q.size() < D)));
        check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        check("out_result", 32'(out_result), 32'(h.res));
        check("out_sel", 32'(out_sel), 32'(h.sel));
        check("out_tag", 32'(out_tag), 32'(h.tag));
        check("out_err", 32'(out_err), 32'(h.err));
        check("op_count", 32'(op_count), 32'(m_cnt));
        check("au_a", 32'(au_a), 32'(m_a));
        check("au_b", 32'(au_b), 32'(m_b));
        check("au_sel", 32'(au_sel), 32'(m_sel));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    // Single op from idle/empty, with hand-computed literal expectations.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s,
                         input logic [T-1:0] tg, input logic [W-1:0] res, input logic err);
        out_ready = 0;
        in_valid = 1; in_a = a; in_b = b; in_sel = s; in_tag = tg;
        step();
        in_valid = 0;
        check("lit_valid_early", 32'(out_valid), 32'd0);
        step();
        check("lit_valid", 32'(out_valid), 32'd1);
        check("lit_result", 32'(out_result), 32'(res));
        check("lit_tag", 32'(out_tag), 32'(tg));
        check("lit_err", 32'(out_err), 32'(err));
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    initial begin
        logic [T-1:0] tg;

        rst = 1;
        step();
        step();
        rst = 0;
        check("lit_rst_valid", 32'(out_valid), 32'd0);
        check("lit_rst_count", 32'(op_count), 32'd0);
        check("lit_rst_ready", 32'(in_ready), 32'd1);

        do_op(4'd3, 4'd5, 2'b00, 2'd0, 4'd8, 1'b0);
        do_op(4'd7, 4'd2, 2'b01, 2'd1, 4'd5, 1'b0);
        do_op(4'd9, 4'd8, 2'b10, 2'd2, 4'd7, 1'b0);
        do_op(4'd15, 4'd1, 2'b11, 2'd3, 4'd0, 1'b0);
        check("lit_count4", 32'(op_count), 32'd4);
        do_op(4'hA, 4'd3, 2'b10, 2'd0, 4'd3, 1'b1);
        do_op(4'hA, 4'd3, 2'b00, 2'd1, 4'hD, 1'b0);

        // Backpressure with continuous requests.
        tg = '0;
        out_ready = 0;
        in_valid = 1;
        for (int i = 0; i < 6; i++) begin
            in_a = 4'(i); in_b = 4'd1; in_sel = 2'b00; in_tag = tg;
            step();
            if (last_acc) tg = tg + 1'b1;
        end
        check("lit_bp_ready", 32'(in_ready), 32'd0);
        check("lit_bp_head", 32'(out_tag), 32'd0);
        out_ready = 1;
        in_tag = tg;
        step();
        out_ready = 0;
        check("lit_bp_head2", 32'(out_tag), 32'd1);
        step();
        in_valid = 0;
        step();
        out_ready = 1;
        for (int i = 0; i < 4; i++) step();
        out_ready = 0;

        // Push and pop on the same edge with one entry held.
        in_valid = 1; in_a = 4'd1; in_b = 4'd1; in_sel = 2'b00; in_tag = 2'd1;
        step();
        in_valid = 0;
        step();
        in_valid = 1; in_tag = 2'd2;
        step();
        in_valid = 0;
        out_ready = 1;
        step();
        out_ready = 0;
        check("lit_pp_valid", 32'(out_valid), 32'd1);
        check("lit_pp_tag", 32'(out_tag), 32'd2);
        out_ready = 1;
        step();
        step();
        out_ready = 0;

        // Reset while an op is executing.
        in_valid = 1; in_a = 4'd5; in_b = 4'd6; in_sel = 2'b01; in_tag = 2'd3;
        step();
        in_valid = 0;
        rst = 1;
        step();
        rst = 0;
        check("lit_mid_valid", 32'(out_valid), 32'd0);
        check("lit_mid_count", 32'(op_count), 32'd0);
        check("lit_mid_au_a", 32'(au_a), 32'd0);
        check("lit_mid_au_b", 32'(au_b), 32'd0);
        check("lit_mid_au_sel", 32'(au_sel), 32'd0);
        check("lit_mid_ready", 32'(in_ready), 32'd1);
        out_ready = 1;
        for (int i = 0; i < 3; i++) step();

        // Ten back-to-back ops with the consumer always ready.
        in_valid = 1;
        for (int i = 0; i < 20; i++) begin
            in_a = 4'($urandom); in_b = 4'($urandom); in_sel = 2'($urandom);
            in_tag = 2'(i / 2);
            step();
        end
        in_valid = 0;
        step();
        step();
        check("lit_wrap_count", 32'(op_count), 32'd10);

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(63) == 0);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            in_a      = 4'($urandom);
            in_b      = 4'($urandom);
            in_sel    = 2'($urandom);
            in_tag    = 2'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
